// File: rtl/manchester_frame_deframer_pkg.sv
// Shared frame-format definitions for the Manchester deframer and the serializer-side framer.
package manchester_frame_deframer_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT      = 8'hD5;
    localparam int         MAX_LEN_DEFAULT        = 64;
    localparam int         TIMEOUT_CYCLES_DEFAULT = 1024;
    localparam int         CNT_W_DEFAULT          = 16;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHK     = 2'd3
    } frame_state_t;

endpackage

// File: rtl/manchester_frame_deframer_frame_idle_timer.sv
// Idle-cycle counter: counts enabled cycles without a clear; expired flags the TIMEOUT_CYCLES-th one.
module frame_idle_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt;

    // Saturates at LIMIT so expired stays high while an abort waits on the output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || !enable) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = enable && !clear && (cnt == LIMIT);

endmodule

// File: rtl/manchester_frame_deframer.sv
// Extracts SYNC|LEN|payload|CHK frames from the decoded byte stream and forwards the payload.
module manchester_frame_deframer
    import manchester_frame_deframer_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         MAX_LEN        = MAX_LEN_DEFAULT,
    parameter int         TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int         CNT_W          = CNT_W_DEFAULT
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser,
    output logic             frame_ok,
    output logic             frame_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int         REM_W     = $clog2(MAX_LEN + 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    frame_state_t     state, next_state;
    logic [REM_W-1:0] rem;
    logic [7:0]       chk;
    logic [7:0]       hold_data;
    logic             hold_vld;
    logic             accept, can_load, len_bad, expired, abort;
    logic             ld_out, ld_last, ld_user, ok_set, err_set;

    assign can_load      = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = (state == ST_HUNT) || (state == ST_LEN) || can_load;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign len_bad       = (s_axis_tdata == 8'd0) || (s_axis_tdata > MAX_LEN_B);
    // A pending abort with a held byte must wait for the output register to free up
    assign abort         = expired && (!hold_vld || can_load);

    frame_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk    (aclk),
        .rst    (areset),
        .clear  (accept),
        .enable (state != ST_HUNT),
        .expired(expired)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= ST_HUNT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ld_out     = 1'b0;
        ld_last    = 1'b0;
        ld_user    = 1'b0;
        ok_set     = 1'b0;
        err_set    = 1'b0;
        case (state)
            ST_HUNT: begin
                if (accept && s_axis_tdata == SYNC_BYTE) next_state = ST_LEN;
            end
            ST_LEN: begin
                if (accept) begin
                    next_state = len_bad ? ST_HUNT : ST_PAYLOAD;
                    err_set    = len_bad;
                end else if (abort) begin
                    next_state = ST_HUNT;
                    err_set    = 1'b1;
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    ld_out = hold_vld;
                    if (rem == REM_W'(1)) next_state = ST_CHK;
                end else if (abort) begin
                    next_state = ST_HUNT;
                    err_set    = 1'b1;
                    ld_out     = hold_vld;
                    ld_last    = 1'b1;
                    ld_user    = 1'b1;
                end
            end
            ST_CHK: begin
                if (accept) begin
                    next_state = ST_HUNT;
                    ld_out     = 1'b1;
                    ld_last    = 1'b1;
                    ld_user    = (s_axis_tdata != chk);
                    ok_set     = (s_axis_tdata == chk);
                    err_set    = (s_axis_tdata != chk);
                end else if (abort) begin
                    next_state = ST_HUNT;
                    err_set    = 1'b1;
                    ld_out     = hold_vld;
                    ld_last    = 1'b1;
                    ld_user    = 1'b1;
                end
            end
            default: next_state = ST_HUNT;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= 8'd0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            hold_vld      <= 1'b0;
            frame_ok      <= 1'b0;
            frame_err     <= 1'b0;
            frame_cnt     <= '0;
            err_cnt       <= '0;
        end else begin
            if (ld_out) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= hold_data;
                m_axis_tlast  <= ld_last;
                m_axis_tuser  <= ld_user;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (next_state == ST_HUNT) begin
                hold_vld <= 1'b0;
            end else if (state == ST_PAYLOAD && accept) begin
                hold_vld <= 1'b1;
            end
            frame_ok  <= ok_set;
            frame_err <= err_set;
            if (ok_set)  frame_cnt <= sat_inc(frame_cnt);
            if (err_set) err_cnt   <= sat_inc(err_cnt);
        end
    end

    // Payload datapath; qualified by state/hold_vld so it needs no reset
    always_ff @(posedge aclk) begin
        if (accept && state == ST_LEN) begin
            rem <= REM_W'(s_axis_tdata);
            chk <= s_axis_tdata;
        end else if (accept && state == ST_PAYLOAD) begin
            rem       <= rem - 1'b1;
            chk       <= chk ^ s_axis_tdata;
            hold_data <= s_axis_tdata;
        end
    end

endmodule

// File: tb/tb_manchester_frame_deframer.sv
// Scoreboard bench for manchester_frame_deframer: directed frames, stalls, timeout and reset.
module tb_manchester_frame_deframer;

    localparam int TO = 32;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    logic        aclk = 1'b0;
    logic        areset = 1'b0;
    logic [7:0]  s_axis_tdata = 8'd0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        frame_ok;
    logic        frame_err;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    obs_ok = 0;
    int    obs_err = 0;
    int    exp_ok = 0;
    int    exp_err = 0;
    bit    toggle_en = 1'b0;
    bit    prev_stall = 1'b0;
    beat_t prev_beat;

    always #5 aclk = ~aclk;

    manchester_frame_deframer #(
        .SYNC_BYTE(8'hD5),
        .MAX_LEN(64),
        .TIMEOUT_CYCLES(TO),
        .CNT_W(16)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser),
        .frame_ok(frame_ok),
        .frame_err(frame_err),
        .frame_cnt(frame_cnt),
        .err_cnt(err_cnt)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: samples on the falling edge, between input updates and the next active edge
    always @(negedge aclk) begin
        if (!areset) begin
            beat_t cur;
            cur = '{d: m_axis_tdata, l: m_axis_tlast, u: m_axis_tuser};
            if (prev_stall) begin
                check("stall_valid_held", int'(m_axis_tvalid), 1);
                check("stall_beat_stable", int'(cur), int'(prev_beat));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", int'(cur), -1);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat", int'(cur), int'(e));
                end
            end
            if (!s_axis_tready) check("s_tready_drop_only_when_blocked",
                                      int'(m_axis_tvalid && !m_axis_tready), 1);
            if (frame_ok || frame_err) check("ok_err_exclusive", int'(frame_ok && frame_err), 0);
            if (frame_ok)  obs_ok++;
            if (frame_err) obs_err++;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_beat  = cur;
        end
    end

    always @(posedge aclk) begin
        #1;
        if (toggle_en) m_axis_tready = ~m_axis_tready;
    end

    task automatic push_beat(input logic [7:0] d, input logic l, input logic u);
        exp_q.push_back('{d: d, l: l, u: u});
    endtask

    task automatic send(input logic [7:0] b);
        bit rdy;
        int n;
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        n = 0;
        do begin
            @(negedge aclk);
            rdy = s_axis_tready;
            @(posedge aclk);
            #1;
            n++;
        end while (!rdy && n < 200);
        if (!rdy) check("send_accept_timeout", 0, 1);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge aclk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check({name, "_drain_timeout"}, exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (3) @(posedge aclk);
        #1;
        check({name, "_ok_pulses"}, obs_ok, exp_ok);
        check({name, "_err_pulses"}, obs_err, exp_err);
    endtask

    task automatic good_frame();
        send(8'hD5); send(8'h03);
        push_beat(8'hF0, 1'b0, 1'b0); push_beat(8'h0F, 1'b0, 1'b0); push_beat(8'hAA, 1'b1, 1'b0);
        send(8'hF0); send(8'h0F); send(8'hAA); send(8'h56);
        exp_ok++;
    endtask

    initial begin
        #1 areset = 1'b1;
        #3;
        check("rst_m_tvalid", int'(m_axis_tvalid), 0);
        check("rst_m_tdata", int'(m_axis_tdata), 0);
        check("rst_s_tready", int'(s_axis_tready), 1);
        check("rst_flags", int'({m_axis_tlast, m_axis_tuser, frame_ok, frame_err}), 0);
        check("rst_cnts", int'({frame_cnt, err_cnt}), 0);
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        @(posedge aclk);
        #1;

        // 1: good frame
        good_frame();
        drain("t1");
        check("t1_frame_cnt", int'(frame_cnt), 1);

        // 2: checksum error
        send(8'hD5); send(8'h03);
        push_beat(8'hF0, 1'b0, 1'b0); push_beat(8'h0F, 1'b0, 1'b0); push_beat(8'hAA, 1'b1, 1'b1);
        send(8'hF0); send(8'h0F); send(8'hAA); send(8'h57);
        exp_err++;
        drain("t2");
        check("t2_err_cnt", int'(err_cnt), 1);

        // 3: garbage, LEN=0, then a one-byte frame carrying D5 as LEN-adjacent data
        send(8'h11); send(8'h22); send(8'hD5); send(8'h00);
        exp_err++;
        drain("t3a");
        send(8'hD5); send(8'h01);
        push_beat(8'h5A, 1'b1, 1'b0);
        send(8'h5A); send(8'h5B);
        exp_ok++;
        drain("t3b");
        check("t3_err_cnt", int'(err_cnt), 2);

        // 4: downstream stalls every other cycle
        toggle_en = 1'b1;
        good_frame();
        drain("t4");
        toggle_en = 1'b0;
        @(posedge aclk);
        #1 m_axis_tready = 1'b1;
        check("t4_frame_cnt", int'(frame_cnt), 3);

        // 5: timeout mid-payload flushes the held byte as an errored tlast
        send(8'hD5); send(8'h03);
        push_beat(8'hF0, 1'b0, 1'b0); push_beat(8'h0F, 1'b1, 1'b1);
        send(8'hF0); send(8'h0F);
        exp_err++;
        repeat (TO + 8) @(posedge aclk);
        #1;
        drain("t5a");
        check("t5_err_cnt", int'(err_cnt), 3);
        good_frame();
        drain("t5b");
        check("t5_frame_cnt", int'(frame_cnt), 4);

        // 6: reset while F0 sits in the output register
        send(8'hD5); send(8'h03); send(8'hF0); send(8'h0F);
        areset = 1'b1;
        #1;
        check("t6_m_tvalid", int'(m_axis_tvalid), 0);
        check("t6_m_tdata", int'(m_axis_tdata), 0);
        check("t6_cnts", int'({frame_cnt, err_cnt}), 0);
        check("t6_s_tready", int'(s_axis_tready), 1);
        @(posedge aclk);
        #1 areset = 1'b0;
        obs_ok = 0; obs_err = 0; exp_ok = 0; exp_err = 0;
        @(posedge aclk);
        #1;
        good_frame();
        drain("t6");
        check("t6_frame_cnt", int'(frame_cnt), 1);
        check("t6_err_cnt", int'(err_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
